// File: rtl/knob_pkg.sv
// Shared encodings for the front-panel rotary input blocks (driver and value stages).
package knob_pkg;

  typedef enum logic {
    KNOB_SLOW = 1'b0,
    KNOB_FAST = 1'b1
  } knob_state_e;

  localparam logic KNOB_DIR_UP   = 1'b0;
  localparam logic KNOB_DIR_DOWN = 1'b1;

endpackage

// File: rtl/module_knob_gap_timer.sv
// Saturating cycle counter measuring the gap between accepted step pulses.
module module_knob_gap_timer #(
  parameter int unsigned FAST_WINDOW = 500000
) (
  input  logic qzt_clk,
  input  logic rst_n,
  input  logic clear,
  input  logic preset,
  output logic at_limit,
  output logic reaching
);

  localparam int unsigned CW = $clog2(FAST_WINDOW + 1);
  localparam logic [CW-1:0] LIMIT = CW'(FAST_WINDOW);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (preset) begin
      count_d = LIMIT;
    end else if (clear) begin
      count_d = '0;
    end else if (count_q != LIMIT) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge qzt_clk) begin
    if (!rst_n) begin
      count_q <= LIMIT;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_limit = (count_q == LIMIT);
  // High in the cycle whose edge loads LIMIT, so FAST can be left on that same edge.
  assign reaching = (count_d == LIMIT);

endmodule

// File: rtl/module_knob_value.sv
// Bounded front-panel setting with velocity acceleration, preset load and change strobe.
module module_knob_value
  import knob_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MIN_VAL     = 0,
  parameter int unsigned MAX_VAL     = 99,
  parameter int unsigned SLOW_STEP   = 1,
  parameter int unsigned FAST_STEP   = 10,
  parameter int unsigned FAST_WINDOW = 500000,
  parameter int unsigned ACCEL_COUNT = 3
) (
  input  logic             qzt_clk,
  input  logic             rst_n,
  input  logic             pulse,
  input  logic             direction,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             changed,
  output logic             fast
);

  typedef logic [WIDTH:0]   ext_t;
  typedef logic [WIDTH+1:0] wide_t;

  localparam int unsigned SW = $clog2(ACCEL_COUNT + 1);
  localparam ext_t MIN_X  = ext_t'(MIN_VAL);
  localparam ext_t MAX_X  = ext_t'(MAX_VAL);
  localparam ext_t SLOW_X = ext_t'(SLOW_STEP);
  localparam ext_t FAST_X = ext_t'(FAST_STEP);
  localparam logic [SW-1:0] ACCEL_S = SW'(ACCEL_COUNT);

  knob_state_e      state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             changed_q, changed_d;
  logic             fast_q, fast_d;
  logic [SW-1:0]    streak_q, streak_d;
  logic             last_dir_q, last_dir_d;

  logic gap_clear, gap_preset, gap_at_limit, gap_reaching;
  logic quick;
  ext_t step;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    wide_t below;
    // Borrow out of v - MIN_VAL flags values under the lower bound.
    below = {2'b00, v} - {1'b0, MIN_X};
    if (below[WIDTH+1]) begin
      return MIN_X[WIDTH-1:0];
    end else if ({1'b0, v} > MAX_X) begin
      return MAX_X[WIDTH-1:0];
    end else begin
      return v;
    end
  endfunction

  function automatic logic [WIDTH-1:0] apply_step(input logic [WIDTH-1:0] cur,
                                                  input logic dir,
                                                  input ext_t stp);
    ext_t cur_x;
    ext_t sum;
    cur_x = {1'b0, cur};
    sum   = cur_x + stp;
    if (dir == KNOB_DIR_DOWN) begin
      if (cur_x < MIN_X + stp) begin
`ifdef KNOB_WRAP_EN
        return MAX_X[WIDTH-1:0];
`else
        return MIN_X[WIDTH-1:0];
`endif
      end else begin
        return cur - stp[WIDTH-1:0];
      end
    end else begin
      if (sum > MAX_X) begin
`ifdef KNOB_WRAP_EN
        return MIN_X[WIDTH-1:0];
`else
        return MAX_X[WIDTH-1:0];
`endif
      end else begin
        return sum[WIDTH-1:0];
      end
    end
  endfunction

  module_knob_gap_timer #(
    .FAST_WINDOW(FAST_WINDOW)
  ) u_gap_timer (
    .qzt_clk (qzt_clk),
    .rst_n   (rst_n),
    .clear   (gap_clear),
    .preset  (gap_preset),
    .at_limit(gap_at_limit),
    .reaching(gap_reaching)
  );

  assign quick = !gap_at_limit && (direction == last_dir_q);

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    streak_d   = streak_q;
    last_dir_d = last_dir_q;
    gap_clear  = 1'b0;
    gap_preset = 1'b0;
    step       = SLOW_X;

    if (load) begin
      // Load swallows any coincident pulse: timer, streak and last_dir untouched by it.
      value_d    = clamp_load(load_value);
      state_d    = KNOB_SLOW;
      streak_d   = '0;
      gap_preset = 1'b1;
    end else if (pulse) begin
      gap_clear  = 1'b1;
      last_dir_d = direction;
      case (state_q)
        KNOB_SLOW: begin
          step = SLOW_X;
          if (quick) begin
            if (streak_q != ACCEL_S) begin
              streak_d = streak_q + SW'(1);
            end
            if (streak_d == ACCEL_S) begin
              state_d = KNOB_FAST;
            end
          end else begin
            streak_d = SW'(1);
          end
        end
        KNOB_FAST: begin
          if (direction != last_dir_q) begin
            step     = SLOW_X;
            state_d  = KNOB_SLOW;
            streak_d = SW'(1);
          end else begin
            step = FAST_X;
          end
        end
        default: begin
          state_d  = KNOB_SLOW;
          streak_d = '0;
        end
      endcase
      value_d = apply_step(value_q, direction, step);
    end else if (state_q == KNOB_FAST && gap_reaching) begin
      state_d  = KNOB_SLOW;
      streak_d = '0;
    end

    changed_d = (value_d != value_q);
    fast_d    = (state_d == KNOB_FAST);
  end

  always_ff @(posedge qzt_clk) begin
    if (!rst_n) begin
      state_q    <= KNOB_SLOW;
      value_q    <= MIN_X[WIDTH-1:0];
      changed_q  <= 1'b0;
      fast_q     <= 1'b0;
      streak_q   <= '0;
      last_dir_q <= KNOB_DIR_UP;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      changed_q  <= changed_d;
      fast_q     <= fast_d;
      streak_q   <= streak_d;
      last_dir_q <= last_dir_d;
    end
  end

  assign value   = value_q;
  assign changed = changed_q;
  assign fast    = fast_q;

endmodule
